// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam int unsigned INSTR_SIZE    = 4;

   typedef enum logic [1:0] {
      FETCH_ST_RUN  = 2'd0,
      FETCH_ST_WAIT = 2'd1,
      FETCH_ST_DROP = 2'd2
   } fetch_st_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small {pc,instr} queue between the imem response and the IF/ID boundary.
module fetch_fifo #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_push,
   input  logic [XLEN-1:0] i_push_pc,
   input  logic [XLEN-1:0] i_push_instr,
   input  logic            i_pop,
   input  logic            i_flush,
   output logic [CW-1:0]   o_count,
   output logic            o_head_valid,
   output logic [XLEN-1:0] o_head_pc,
   output logic [XLEN-1:0] o_head_instr
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [XLEN-1:0] r_pc    [DEPTH];
   logic [XLEN-1:0] r_instr [DEPTH];
   logic [AW-1:0]   r_rd;
   logic [AW-1:0]   r_wr;
   logic [CW-1:0]   r_count;
   logic            w_full;
   logic            w_do_pop;
   logic            w_do_push;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && (r_count != '0);
   // A push into a full queue is only taken when the head leaves in the same cycle.
   assign w_do_push = i_push && (!w_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_pc[r_wr]    <= i_push_pc;
         r_instr[r_wr] <= i_push_instr;
      end
   end

   assign o_count      = r_count;
   assign o_head_valid = (r_count != '0);
   assign o_head_pc    = r_pc[r_rd];
   assign o_head_instr = r_instr[r_rd];

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, keeps at most one imem read in flight, feeds ID from a queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
   parameter int unsigned     DEPTH     = 2,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_st_e       r_state;
   fetch_st_e       w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_req_pc_nxt;
   logic [XLEN-1:0] w_redir_tgt;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_occ;
   logic            w_space;
   logic            w_req;
   logic            w_accept;
   logic            w_push;
   logic            w_pop;
   logic            w_head_valid;
   logic [XLEN-1:0] w_head_pc;
   logic [XLEN-1:0] w_head_instr;

   assign w_redir_tgt = redirect_pc & ~XLEN'(3);
   assign w_occ       = w_count + CW'(r_state != FETCH_ST_RUN);
   assign w_space     = (w_occ < CW'(DEPTH));
   assign w_req       = !redirect_valid && w_space &&
                        ((r_state == FETCH_ST_RUN) ||
                         ((r_state == FETCH_ST_WAIT) && imem_rvalid));
   assign w_accept    = w_req && imem_ready;
   assign w_pop       = w_head_valid && id_ready && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= FETCH_ST_RUN;
         r_pc     <= RESET_PC;
         r_req_pc <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_req_pc <= w_req_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_pc_nxt = r_req_pc;
      w_push       = 1'b0;
      if (redirect_valid) begin
         w_pc_nxt = w_redir_tgt;
         // A stale response arriving alongside the redirect still retires the outstanding read.
         case (r_state)
            FETCH_ST_WAIT: w_state_nxt = imem_rvalid ? FETCH_ST_RUN : FETCH_ST_DROP;
            FETCH_ST_DROP: w_state_nxt = imem_rvalid ? FETCH_ST_RUN : FETCH_ST_DROP;
            default:       w_state_nxt = FETCH_ST_RUN;
         endcase
      end else begin
         case (r_state)
            FETCH_ST_RUN: begin
               if (w_accept) w_state_nxt = FETCH_ST_WAIT;
            end
            FETCH_ST_WAIT: begin
               if (imem_rvalid) begin
                  w_push      = 1'b1;
                  w_state_nxt = w_accept ? FETCH_ST_WAIT : FETCH_ST_RUN;
               end
            end
            FETCH_ST_DROP: begin
               if (imem_rvalid) w_state_nxt = FETCH_ST_RUN;
            end
            default: w_state_nxt = FETCH_ST_RUN;
         endcase
         if (w_accept) begin
            w_req_pc_nxt = r_pc;
            w_pc_nxt     = r_pc + XLEN'(INSTR_SIZE);
         end
      end
   end

   fetch_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_push),
      .i_push_pc    (r_req_pc),
      .i_push_instr (imem_rdata),
      .i_pop        (w_pop),
      .i_flush      (redirect_valid),
      .o_count      (w_count),
      .o_head_valid (w_head_valid),
      .o_head_pc    (w_head_pc),
      .o_head_instr (w_head_instr)
   );

   assign imem_req  = w_req && rst_n;
   assign imem_addr = r_pc;
   assign id_valid  = w_head_valid;
   assign id_instr  = w_head_valid ? w_head_instr : NOP_INSTR;
   assign id_pc     = w_head_valid ? w_head_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, PC wrap and mid-flight reset.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b1;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   logic        auto_mem = 1'b0;
   logic        a_rvalid = 1'b0;
   logic [31:0] a_rdata = '0;
   logic        m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_addr;
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN      (32),
      .RESET_PC  (32'h0000_0000),
      .DEPTH     (2),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Latency-1 memory used while auto_mem is set
   always @(posedge clk) begin
      a_rvalid <= auto_mem && imem_req && imem_ready;
      a_rdata  <= mem_word(imem_addr);
   end

   assign imem_rvalid = auto_mem ? a_rvalid : m_rvalid;
   assign imem_rdata  = auto_mem ? a_rdata  : m_rdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         if (imem_req && imem_ready) begin
            chk("stream_addr", imem_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
         end
         if (id_valid && id_ready && !redirect_valid) begin
            chk("stream_pc", id_pc, exp_pc);
            chk("stream_instr", id_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end else if (!id_valid) begin
            chk("empty_instr", id_instr, NOP);
         end
         tick();
      end
   endtask

   initial begin
      // Reset values
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_instr", id_instr, NOP);
      chk("rst_pc", id_pc, 32'd0);

      // 1: streaming at L=1
      tick();
      auto_mem = 1'b1;
      rst_n = 1'b1;
      exp_addr = 32'd0;
      exp_pc = 32'd0;
      run_cycles(2);
      #1;
      chk("first_valid", {31'd0, id_valid}, 32'd1);
      chk("first_pc", id_pc, 32'd0);
      chk("first_instr", id_instr, mem_word(32'd0));
      run_cycles(20);

      // 2: ID stall fills the queue, then resumes in order
      id_ready = 1'b0;
      run_cycles(10);
      #1;
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
      chk("stall_head", id_pc, exp_pc);
      id_ready = 1'b1;
      run_cycles(15);

      // Fresh start with manually driven memory
      auto_mem = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("t3_req0", {31'd0, imem_req}, 32'd1);
      chk("t3_addr0", imem_addr, 32'd0);
      tick();

      // 3: redirect while WAIT, stale response three cycles later
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      chk("t3_redir_req", {31'd0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("t3_drop_req", {31'd0, imem_req}, 32'd0);
      chk("t3_drop_valid", {31'd0, id_valid}, 32'd0);
      tick();
      #1;
      chk("t3_drop_req2", {31'd0, imem_req}, 32'd0);
      tick();
      m_rvalid = 1'b1;
      m_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t3_drop_req3", {31'd0, imem_req}, 32'd0);
      tick();
      m_rvalid = 1'b0;
      #1;
      chk("t3_tgt_req", {31'd0, imem_req}, 32'd1);
      chk("t3_tgt_addr", imem_addr, 32'h0000_0100);
      chk("t3_discard", {31'd0, id_valid}, 32'd0);
      tick();
      m_rvalid = 1'b1;
      m_rdata = 32'h1111_1111;
      imem_ready = 1'b0;
      #1;
      chk("t3_next_req", {31'd0, imem_req}, 32'd1);
      chk("t3_next_addr", imem_addr, 32'h0000_0104);
      tick();
      m_rvalid = 1'b0;
      #1;
      chk("t3_id_valid", {31'd0, id_valid}, 32'd1);
      chk("t3_id_pc", id_pc, 32'h0000_0100);
      chk("t3_id_instr", id_instr, 32'h1111_1111);
      tick();
      #1;
      chk("t3_popped", {31'd0, id_valid}, 32'd0);
      chk("t3_nop", id_instr, NOP);

      // 4: redirect and rvalid in the same cycle
      imem_ready = 1'b1;
      tick();
      m_rvalid = 1'b1;
      m_rdata = 32'h0BAD_0BAD;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      #1;
      chk("t4_req", {31'd0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      m_rvalid = 1'b0;
      imem_ready = 1'b0;
      #1;
      chk("t4_run_req", {31'd0, imem_req}, 32'd1);
      chk("t4_run_addr", imem_addr, 32'h0000_0200);
      chk("t4_dropped", {31'd0, id_valid}, 32'd0);

      // 5: request held while not ready, then withdrawn by redirect
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         chk("t5_hold_req", {31'd0, imem_req}, 32'd1);
         chk("t5_hold_addr", imem_addr, 32'h0000_0200);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0300;
      #1;
      chk("t5_withdraw", {31'd0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      imem_ready = 1'b1;
      #1;
      chk("t5_tgt_req", {31'd0, imem_req}, 32'd1);
      chk("t5_tgt_addr", imem_addr, 32'h0000_0300);
      tick();

      // 6: PC wrap, then reset mid-WAIT
      m_rvalid = 1'b1;
      m_rdata = 32'h1234_5678;
      imem_ready = 1'b0;
      tick();
      m_rvalid = 1'b0;
      #1;
      chk("t6_head_pc", id_pc, 32'h0000_0300);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      imem_ready = 1'b1;
      #1;
      chk("t6_flushed", {31'd0, id_valid}, 32'd0);
      chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      m_rvalid = 1'b1;
      m_rdata = 32'h5555_5555;
      #1;
      chk("t6_wrap_req", {31'd0, imem_req}, 32'd1);
      chk("t6_wrap_addr", imem_addr, 32'h0000_0000);
      tick();
      m_rvalid = 1'b0;
      #1;
      chk("t6_top_pc", id_pc, 32'hFFFF_FFFC);
      chk("t6_top_instr", id_instr, 32'h5555_5555);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
      chk("t6_rst_valid", {31'd0, id_valid}, 32'd0);
      chk("t6_rst_instr", id_instr, NOP);
      chk("t6_rst_pc", id_pc, 32'd0);
      tick();
      imem_ready = 1'b0;
      m_rvalid = 1'b1;
      m_rdata = 32'h7777_7777;
      tick();
      rst_n = 1'b1;
      #1;
      chk("t6_restart_addr", imem_addr, 32'h0000_0000);
      tick();
      m_rvalid = 1'b0;
      #1;
      chk("t6_late_ignored", {31'd0, id_valid}, 32'd0);
      chk("t6_restart_req", {31'd0, imem_req}, 32'd1);
      chk("t6_restart_addr2", imem_addr, 32'h0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
